turbo_deinterleaver: RTL and testbench



---
 rtl/turbo_deinterleaver.sv | 157 +++++++++++++++
 tb/tb_turbo_deinterleaver.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_deinterleaver.sv
// Row/column block de-interleaver: column-major writes, row-major reads, valid/ready on both sides.
// Define DEINT_PINGPONG_EN for a two-bank build in which fill and drain of consecutive blocks overlap.
module turbo_deinterleaver #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);
  localparam int N = ROWS * COLS;
  localparam logic [ADDR_W-1:0] ROWS_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] N_LAST    = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
`ifdef DEINT_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int PTR_W = ADDR_W + BANKS - 1;

  logic [ADDR_W-1:0] wr_r_q, wr_r_d, wr_c_q, wr_c_d, rd_a_q, rd_a_d;
  logic [ADDR_W-1:0] wr_addr;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              wr_fire, rd_fire, wr_done, rd_done;
  logic [DATA_W-1:0] mem_q [BANKS*N];

  // Sample k = wr_c*ROWS + wr_r lands at its row-major slot, so reads simply count up.
  assign wr_addr = wr_r_q * COLS_A + wr_c_q;
  assign wr_fire = valid_i && ready_o && !flush_i;
  assign rd_fire = valid_o && ready_i && !flush_i;
  assign wr_done = wr_fire && (wr_r_q == ROWS_LAST) && (wr_c_q == COLS_LAST);
  assign rd_done = rd_fire && (rd_a_q == N_LAST);
  assign last_o  = valid_o && (rd_a_q == N_LAST);
  assign data_o  = valid_o ? mem_q[rd_ptr] : '0;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    wr_r_d = wr_r_q;
    wr_c_d = wr_c_q;
    rd_a_d = rd_a_q;
    if (flush_i) begin
      wr_r_d = '0;
      wr_c_d = '0;
      rd_a_d = '0;
    end else begin
      if (wr_fire) begin
        if (wr_r_q == ROWS_LAST) begin
          wr_r_d = '0;
          wr_c_d = (wr_c_q == COLS_LAST) ? '0 : wr_c_q + ONE;
        end else begin
          wr_r_d = wr_r_q + ONE;
        end
      end
      if (rd_fire) rd_a_d = (rd_a_q == N_LAST) ? '0 : rd_a_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_r_q <= '0;
      wr_c_q <= '0;
      rd_a_q <= '0;
    end else begin
      wr_r_q <= wr_r_d;
      wr_c_q <= wr_c_d;
      rd_a_q <= rd_a_d;
    end
  end

  // NOTE: the symbol array has no reset; data_o is masked until a full block has been written.
  always_ff @(posedge clk_p_i) begin
    if (wr_fire) mem_q[wr_ptr] <= data_i;
  end

`ifdef DEINT_PINGPONG_EN
  localparam logic [PTR_W-1:0] N_P = PTR_W'(N);

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;

  assign ready_o = !full_q[wr_bank_q];
  assign valid_o = full_q[rd_bank_q];
  assign wr_ptr  = {1'b0, wr_addr} + (wr_bank_q ? N_P : '0);
  assign rd_ptr  = {1'b0, rd_a_q}  + (rd_bank_q ? N_P : '0);

  // A completing write always targets the empty bank and a completing read the full one,
  // so both flag updates can apply on the same edge.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (flush_i) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end else begin
      if (wr_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
      if (rd_done) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end
`else
  typedef enum logic {S_FILL, S_DRAIN} state_e;
  state_e state_q, state_d;

  assign ready_o = (state_q == S_FILL);
  assign valid_o = (state_q == S_DRAIN);
  assign wr_ptr  = wr_addr;
  assign rd_ptr  = rd_a_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (wr_done) state_d = S_DRAIN;
      S_DRAIN: if (rd_done) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
    if (flush_i) state_d = S_FILL;
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_FILL;
    else            state_q <= state_d;
  end
`endif

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Scoreboard bench for turbo_deinterleaver: 4x8 main instance plus a 2x2 boundary instance.
module tb_turbo_deinterleaver;
  localparam int DATA_W = 16;
  localparam int ROWS   = 4;
  localparam int COLS   = 8;
  localparam int ADDR_W = 5;
  localparam int N      = ROWS * COLS;
  localparam int TMO    = 400;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [DATA_W-1:0] data_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic              last_o;

  logic              b_valid_i = 1'b0;
  logic              b_ready_o;
  logic [DATA_W-1:0] b_data_i = '0;
  logic              b_valid_o;
  logic              b_ready_i = 1'b0;
  logic [DATA_W-1:0] b_data_o;
  logic              b_last_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W:0] exp_q[$];

  turbo_deinterleaver #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk_p_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o)
  );

  turbo_deinterleaver #(.DATA_W(DATA_W), .ROWS(2), .COLS(2), .ADDR_W(2)) dut_b (
    .clk_p_i(clk), .reset_n_i(reset_n), .flush_i(1'b0),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .last_o(b_last_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected row-major order of one block whose input k carries value base+k.
  task automatic push_block(input int base);
    for (int j = 0; j < N; j++) begin
      int r, c;
      r = j / COLS;
      c = j % COLS;
      exp_q.push_back({j == N - 1, DATA_W'(base + c * ROWS + r)});
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== '0 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready_o=%b valid_o=%b data_o=%0h last_o=%b, required 1 0 0 0",
               name, ready_o, valid_o, data_o, last_o);
    end
  endtask

  task automatic feed_n(input int base, input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      valid_i = 1'b1;
      data_i  = DATA_W'(base + k);
      for (w = 0; w < TMO; w++) begin
        @(negedge clk);
        if (ready_o === 1'b1) break;
        @(posedge clk); #1;
      end
      checks++;
      if (w >= TMO) begin
        errors++;
        $display("FAIL feed_timeout: input %0d not accepted after %0d cycles, required acceptance", k, w);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic run_block(input string name, input int base, input int nblk, input bit gaps,
                           input int stall_idx, input int stall_len);
    int  acc_cyc, first_cyc;
    bit  overlap, ready_drop;
    acc_cyc    = -1;
    first_cyc  = -1;
    overlap    = 1'b0;
    ready_drop = 1'b0;
    exp_q.delete();
    fork
      begin
        int w, idle;
        for (int b = 0; b < nblk; b++) begin
          push_block(base + b * N);
          for (int k = 0; k < N; k++) begin
            if (gaps) begin
              idle = $urandom_range(0, 2);
              valid_i = 1'b0;
              repeat (idle) begin @(posedge clk); #1; end
            end
            valid_i = 1'b1;
            data_i  = DATA_W'(base + b * N + k);
            for (w = 0; w < TMO; w++) begin
              @(negedge clk);
              if (ready_o !== 1'b1) ready_drop = 1'b1;
              if (ready_o === 1'b1) begin
                if (b == 0 && k == N - 1) acc_cyc = cyc;
                if (valid_o === 1'b1 && ready_i === 1'b1) overlap = 1'b1;
                break;
              end
              @(posedge clk); #1;
            end
            checks++;
            if (w >= TMO) begin
              errors++;
              $display("FAIL %s_in_timeout: input %0d of block %0d not accepted, required acceptance", name, k, b);
            end
            @(posedge clk); #1;
          end
        end
        valid_i = 1'b0;
      end
      begin
        int j, idle_n, stall_n;
        bit holding;
        logic [DATA_W:0] want, held;
        j = 0; idle_n = 0; stall_n = 0; holding = 1'b0; held = '0;
        while (j < nblk * N && idle_n < TMO) begin
          if (j == stall_idx && stall_n < stall_len) begin
            ready_i = 1'b0;
            stall_n++;
          end else begin
            ready_i = 1'b1;
          end
          @(negedge clk);
          if (valid_o === 1'b1) begin
            idle_n = 0;
            if (first_cyc < 0) first_cyc = cyc;
            if (holding) begin
              checks++;
              if ({last_o, data_o} !== held) begin
                errors++;
                $display("FAIL %s_hold: last/data=%b/%0d, required %b/%0d",
                         name, last_o, data_o, held[DATA_W], held[DATA_W-1:0]);
              end
            end
`ifndef DEINT_PINGPONG_EN
            checks++;
            if (ready_o !== 1'b0) begin
              errors++;
              $display("FAIL %s_ready_in_drain: ready_o=%b, required 0", name, ready_o);
            end
`endif
            if (ready_i) begin
              holding = 1'b0;
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_extra_output: data_o=%0d, required no output", name, data_o);
              end else begin
                want = exp_q.pop_front();
                if ({last_o, data_o} !== want) begin
                  errors++;
                  $display("FAIL %s_out[%0d]: last/data=%b/%0d, required %b/%0d",
                           name, j, last_o, data_o, want[DATA_W], want[DATA_W-1:0]);
                end
              end
              j++;
            end else begin
              holding = 1'b1;
              held    = {last_o, data_o};
            end
          end else begin
            idle_n++;
            checks++;
            if (data_o !== '0 || last_o !== 1'b0) begin
              errors++;
              $display("FAIL %s_idle_out: data_o=%0h last_o=%b, required 0 0", name, data_o, last_o);
            end
          end
          @(posedge clk); #1;
        end
        ready_i = 1'b0;
        checks++;
        if (j < nblk * N) begin
          errors++;
          $display("FAIL %s_out_timeout: received %0d outputs, required %0d", name, j, nblk * N);
        end
      end
    join
    checks++;
    if (first_cyc != acc_cyc + 1) begin
      errors++;
      $display("FAIL %s_latency: first valid at cycle %0d, required %0d", name, first_cyc, acc_cyc + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d expected outputs never seen, required 0", name, exp_q.size());
    end
`ifdef DEINT_PINGPONG_EN
    if (!gaps && stall_len == 0) begin
      checks++;
      if (ready_drop) begin
        errors++;
        $display("FAIL %s_ready_drop: ready_o went low during input, required always 1", name);
      end
    end
    if (nblk > 1) begin
      checks++;
      if (!overlap) begin
        errors++;
        $display("FAIL %s_overlap: fill/drain overlap=%b, required 1", name, overlap);
      end
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    checks++;
    if (b_ready_o !== 1'b1 || b_valid_o !== 1'b0 || b_data_o !== '0 || b_last_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_2x2: ready=%b valid=%b data=%0h last=%b, required 1 0 0 0",
               b_ready_o, b_valid_o, b_data_o, b_last_o);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_block("basic", 0, 1, 1'b0, -1, 0);
  endtask

  task automatic test_backpressure();
    run_block("backpressure", 0, 1, 1'b0, 5, 3);
  endtask

  task automatic test_input_gaps();
    run_block("gaps", 1000, 2, 1'b1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_block("back_to_back", 2000, 3, 1'b0, -1, 0);
  endtask

  task automatic test_flush();
    feed_n(500, 10);
    valid_i = 1'b1;
    data_i  = DATA_W'(999);
    flush   = 1'b1;
    @(posedge clk); #1;
    flush   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_flush");
    @(posedge clk); #1;
    run_block("flush_next", 100, 1, 1'b0, -1, 0);
  endtask

  task automatic test_reset_mid_block();
    feed_n(700, 10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_fill");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_block("after_reset", 200, 1, 1'b0, -1, 0);
    ready_i = 1'b0;
    feed_n(300, N);
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || data_o !== DATA_W'(300) || last_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_before_reset: valid/data/last=%b/%0d/%b, required 1/300/0", valid_o, data_o, last_o);
    end
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_drain");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    logic [DATA_W:0] bq[$];
    logic [DATA_W:0] want;
    int got;
    got = 0;
    for (int j = 0; j < 4; j++) bq.push_back({j == 3, DATA_W'((j % 2) * 2 + j / 2)});
    b_ready_i = 1'b1;
    fork
      begin
        int w;
        for (int k = 0; k < 4; k++) begin
          b_valid_i = 1'b1;
          b_data_i  = DATA_W'(k);
          for (w = 0; w < TMO; w++) begin
            @(negedge clk);
            if (b_ready_o === 1'b1) break;
            @(posedge clk); #1;
          end
          @(posedge clk); #1;
        end
        b_valid_i = 1'b0;
      end
      begin
        int idle;
        idle = 0;
        while (got < 4 && idle < TMO) begin
          @(negedge clk);
          if (b_valid_o === 1'b1) begin
            want = bq.pop_front();
            checks++;
            if ({b_last_o, b_data_o} !== want) begin
              errors++;
              $display("FAIL boundary_out[%0d]: last/data=%b/%0d, required %b/%0d",
                       got, b_last_o, b_data_o, want[DATA_W], want[DATA_W-1:0]);
            end
            got++;
          end else begin
            idle++;
          end
          @(posedge clk); #1;
        end
      end
    join
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL boundary_count: received %0d outputs, required 4", got);
    end
    b_ready_i = 1'b0;
  endtask

`ifdef DEINT_PINGPONG_EN
  task automatic test_pingpong();
    run_block("pingpong", 0, 2, 1'b0, -1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_flush();
    test_reset_mid_block();
    test_boundary();
`ifdef DEINT_PINGPONG_EN
    test_pingpong();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
